// File: rtl/tick_gen_pkg.sv
// Shared configuration for the tick generator: channel count, counter width,
// reset divisors derived from the system and target frequencies, channel config struct.
package tick_gen_pkg;

    localparam int tick_nch   = 3;
    localparam int tick_cnt_w = 32;

    localparam longint unsigned clk_freq  = 64'd100_000_000;
    localparam longint unsigned baudrate  = 64'd115_200;
    localparam longint unsigned slow_freq = 64'd10_000_000;
    localparam longint unsigned rtc_freq  = 64'd1_000_000;

    localparam logic [tick_cnt_w-1:0] DIV_UART = tick_cnt_w'(clk_freq / baudrate);
    localparam logic [tick_cnt_w-1:0] DIV_SLOW = tick_cnt_w'(clk_freq / slow_freq);
    localparam logic [tick_cnt_w-1:0] DIV_RTC  = tick_cnt_w'(clk_freq / rtc_freq);
    // Fractional remainder of the baud divisor, in 1/256 cycle units.
    localparam logic [7:0] FRAC_UART = 8'(((clk_freq * 64'd256) / baudrate) % 64'd256);

    localparam logic [tick_nch-1:0][tick_cnt_w-1:0] TICK_DIV_INIT  = {DIV_RTC, DIV_SLOW, DIV_UART};
    localparam logic [tick_nch-1:0][7:0]            TICK_FRAC_INIT = {8'd0, 8'd0, FRAC_UART};

    typedef struct packed {
        logic [tick_cnt_w-1:0] div;
        logic [7:0]            frac;
    } tick_chan_t;

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: down counter, optional fractional accumulator and registered strobe.
// Fractional stretching is compiled in only when TICK_GEN_FRAC_EN is defined.
module tick_chan #(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] DIV_INIT  = CNT_W'(1),
    parameter logic [7:0]       FRAC_INIT = 8'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    input  logic [7:0]       i_wr_frac,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? ONE : d;
    endfunction

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [CNT_W-1:0] w_d_cur;
    logic [CNT_W-1:0] w_d_new;
    logic [CNT_W-1:0] w_reload;

    // Normal reloads use the divisor in force; sync/idle see a same-edge write.
    assign w_d_cur = eff_div(r_div);
    assign w_d_new = eff_div(i_wr ? i_wr_div : r_div);

`ifdef TICK_GEN_FRAC_EN
    logic [7:0] r_frac;
    logic [7:0] r_acc;
    logic [8:0] w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_reload  = w_acc_sum[8] ? w_d_cur : (w_d_cur - ONE);

    // Fraction register and accumulator; a carry stretches the next period by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frac <= FRAC_INIT;
            r_acc  <= 8'd0;
        end else begin
            if (i_wr) begin
                r_frac <= i_wr_frac;
            end
            if (i_sync || !i_en) begin
                r_acc <= 8'd0;
            end else if (r_cnt == ZERO) begin
                r_acc <= w_acc_sum[7:0];
            end
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^{i_wr_frac, FRAC_INIT};
    assign w_reload      = w_d_cur - ONE;
`endif

    // Divisor, counter and strobe; sync and idle both park the counter at D-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div  <= DIV_INIT;
            r_cnt  <= eff_div(DIV_INIT) - ONE;
            r_tick <= 1'b0;
        end else begin
            if (i_wr) begin
                r_div <= i_wr_div;
            end
            if (i_sync || !i_en) begin
                r_cnt  <= w_d_new - ONE;
                r_tick <= 1'b0;
            end else if (r_cnt == ZERO) begin
                r_cnt  <= w_reload;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt - ONE;
                r_tick <= 1'b0;
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: write decode and sync fan-out to NCH channels.
// Define TICK_GEN_FRAC_EN to enable fractional (1/256 cycle) divisors.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                          NCH       = tick_nch,
    parameter int                          CNT_W     = tick_cnt_w,
    parameter logic [NCH-1:0][CNT_W-1:0]   DIV_INIT  = TICK_DIV_INIT,
    parameter logic [NCH-1:0][7:0]         FRAC_INIT = TICK_FRAC_INIT,
    localparam int                         CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [7:0]       wr_frac,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] w_wr_hit;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        // Channel indices at or beyond NCH never match, so such writes are dropped.
        assign w_wr_hit[g] = wr_en && (wr_ch == CH_W'(g));

        tick_chan #(
            .CNT_W     (CNT_W),
            .DIV_INIT  (DIV_INIT[g]),
            .FRAC_INIT (FRAC_INIT[g])
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .i_en      (en[g]),
            .i_sync    (sync),
            .i_wr      (w_wr_hit[g]),
            .i_wr_div  (wr_div),
            .i_wr_frac (wr_frac),
            .o_tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: an event-time model pushes the expected tick vector
// for each edge into a queue; it is popped and compared once the DUT output settles.
module tb_tick_gen;

    localparam int NCH = 3;
    localparam int CW  = 32;
`ifdef TICK_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           sync;
    logic           wr_en;
    logic [NCH-1:0] en;
    logic [NCH-1:0] tick;
    logic [1:0]     wr_ch;
    logic [CW-1:0]  wr_div;
    logic [7:0]     wr_frac;

    tick_gen dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_frac (wr_frac),
        .tick    (tick)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    longint edge_n;
    longint first_tick [NCH];
    longint last_tick  [NCH];
    longint spacing    [NCH];
    longint m_div      [NCH];
    int     m_frac     [NCH];
    int     m_acc      [NCH];
    bit     m_run      [NCH];
    longint m_next     [NCH];
    longint init_div   [NCH] = '{868, 10, 100};
    int     init_frac  [NCH] = '{14, 0, 0};
    logic [NCH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint deff(input longint d);
        return (d < 2) ? 1 : d;
    endfunction

    // Expected tick vector for the coming edge, from the inputs now on the pins.
    task automatic model_edge(output logic [NCH-1:0] e);
        longint d_old;
        int     sum;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_div[i]  = init_div[i];
                m_frac[i] = FRAC_ON ? init_frac[i] : 0;
                m_acc[i]  = 0;
                m_run[i]  = 1'b0;
            end else begin
                d_old = deff(m_div[i]);
                if (wr_en && int'(wr_ch) == i) begin
                    m_div[i]  = longint'(wr_div);
                    m_frac[i] = FRAC_ON ? int'(wr_frac) : 0;
                end
                if (!en[i]) begin
                    m_run[i] = 1'b0;
                    m_acc[i] = 0;
                end else if (sync) begin
                    m_run[i]  = 1'b1;
                    m_acc[i]  = 0;
                    m_next[i] = edge_n + deff(m_div[i]);
                end else begin
                    if (!m_run[i]) begin
                        m_run[i]  = 1'b1;
                        m_next[i] = edge_n + d_old - 1;
                    end
                    if (edge_n == m_next[i]) begin
                        e[i]      = 1'b1;
                        sum       = m_acc[i] + m_frac[i];
                        m_acc[i]  = sum % 256;
                        m_next[i] = edge_n + d_old + ((sum >= 256) ? 1 : 0);
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0] e;
        logic [NCH-1:0] exp_t;
        longint         idx;
        idx = edge_n;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        exp_t = exp_q.pop_front();
        check_eq($sformatf("tick@%0d", idx), 64'(tick), 64'(exp_t));
        for (int i = 0; i < NCH; i++) begin
            if (tick[i] === 1'b1) begin
                if (first_tick[i] < 0) first_tick[i] = idx;
                if (last_tick[i] >= 0) spacing[i] = idx - last_tick[i];
                last_tick[i] = idx;
            end
        end
        edge_n++;
    endtask

    task automatic mark();
        for (int i = 0; i < NCH; i++) first_tick[i] = -1;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < NCH; i++) begin
            first_tick[i] = -1;
            last_tick[i]  = -1;
            spacing[i]    = -1;
        end
    endtask

    initial begin
        longint s;
        longint lt;
        int     cnt;
        reset = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0;
        wr_ch = 2'd0; wr_div = '0; wr_frac = 8'd0;
        edge_n = 0;
        clear_hist();
        repeat (3) step();
        check_eq("rst_tick", 64'(tick), 64'd0);

        // Default divisors from edge 0.
        reset = 1'b0; en = 3'b111; edge_n = 0;
        mark();
        repeat (1800) step();
        check_eq("ch0_first", first_tick[0], 64'd867);
        check_eq("ch1_first", first_tick[1], 64'd9);
        check_eq("ch2_first", first_tick[2], 64'd99);
        check_eq("ch0_period", spacing[0], 64'd868);
        check_eq("ch1_period", spacing[1], 64'd10);
        check_eq("ch2_period", spacing[2], 64'd100);

        // Mid-period rewrite of channel 1, then an out-of-range write.
        repeat (3) step();
        lt = last_tick[1];
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 32'd4;
        step();
        wr_ch = 2'd3; wr_div = 32'd2;
        mark();
        step();
        wr_en = 1'b0;
        repeat (30) step();
        check_eq("ch1_old_period_done", first_tick[1], lt + 10);
        check_eq("ch1_new_period", spacing[1], 64'd4);

        // Divisor 0 and then 1 on channel 2: tick every cycle.
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 32'd0;
        step();
        wr_en = 1'b0;
        repeat (120) step();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick[2] === 1'b1) cnt++;
        end
        check_eq("ch2_div0", 64'(cnt), 64'd10);
        wr_en = 1'b1; wr_div = 32'd1;
        step();
        wr_en = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick[2] === 1'b1) cnt++;
        end
        check_eq("ch2_div1", 64'(cnt), 64'd10);
        wr_en = 1'b1; wr_div = 32'd100;
        step();
        wr_en = 1'b0;
        repeat (5) step();

        // Sync with a simultaneous write of 20 to channel 1.
        sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_div = 32'd20;
        s = edge_n;
        step();
        check_eq("sync_tick", 64'(tick), 64'd0);
        sync = 1'b0; wr_en = 1'b0;
        mark();
        repeat (110) step();
        check_eq("sync_ch1", first_tick[1], s + 20);
        check_eq("sync_ch2", first_tick[2], s + 100);

        // Channel 1 disabled mid-period for 5 cycles.
        repeat (3) step();
        en[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (tick[1] === 1'b1) cnt++;
        end
        check_eq("ch1_idle", 64'(cnt), 64'd0);
        en[1] = 1'b1;
        s = edge_n;
        mark();
        repeat (30) step();
        check_eq("ch1_reenable", first_tick[1], s + 19);

`ifdef TICK_GEN_FRAC_EN
        // Fractional channel 0, D=20 frac=14: 256 periods span 256*20+14 cycles.
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd20; wr_frac = 8'd14; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        mark();
        begin
            int n_per;
            int n_long;
            longint t0;
            n_per = 0; n_long = 0; t0 = -1;
            for (int k = 0; k < 7000 && n_per < 256; k++) begin
                step();
                if (tick[0] === 1'b1) begin
                    if (t0 < 0) begin
                        t0 = last_tick[0];
                    end else begin
                        n_per++;
                        if (spacing[0] == 21) n_long++;
                    end
                end
            end
            check_eq("frac_periods", 64'(n_per), 64'd256);
            check_eq("frac_total", last_tick[0] - t0, 64'(256 * 20 + 14));
            check_eq("frac_long", 64'(n_long), 64'd14);
        end
`endif

        // Reset mid-period returns every channel to its defaults.
        repeat (4) step();
        reset = 1'b1;
        step();
        check_eq("rst_mid", 64'(tick), 64'd0);
        reset = 1'b0;
        s = edge_n;
        mark();
        repeat (120) step();
        check_eq("rst_ch1", first_tick[1], s + 9);
        check_eq("rst_ch2", first_tick[2], s + 99);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
